// File: rtl/switch_debouncer_pkg.sv
// Shared types and helpers for the switch debouncer.
package switch_debouncer_pkg;

  typedef enum logic {ST_STABLE, ST_WAIT} db_state_t;

  // Counter must hold values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_cell.sv
// One switch bit: synchroniser, stable/wait FSM with qualification counter, and
// registered level/rise/fall outputs.
module switch_debounce_cell
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (s != level_q) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (s == level_q) begin
          // Bounce back to the accepted level: drop the pending change.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          level_d = ~level_q;
          rise_d  = ~level_q;
          fall_d  = level_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounced board switches for the clock-mux selects, with per-bit edge pulses
// and a combined change strobe.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned NUM_SW          = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw_raw_in,
  output logic [NUM_SW-1:0] sw_out,
  output logic [NUM_SW-1:0] sw_rise_out,
  output logic [NUM_SW-1:0] sw_fall_out,
  output logic              sw_changed_out
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);

  for (genvar i = 0; i < NUM_SW; i++) begin : g_cell
    switch_debounce_cell #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CntW)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .raw  (sw_raw_in[i]),
      .level(sw_out[i]),
      .rise (sw_rise_out[i]),
      .fall (sw_fall_out[i])
    );
  end

  // Pulses are registered, so this OR adds no input-to-output path.
  assign sw_changed_out = |(sw_rise_out | sw_fall_out);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed scenarios plus random switch activity, checked every cycle against a
// run-length reference model of the debouncer.
module tb_switch_debouncer;

  localparam int unsigned NSw   = 2;
  localparam int unsigned Sync  = 2;
  localparam int unsigned Deb   = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NSw-1:0] sw_raw_in = '0;
  logic [NSw-1:0] sw_out, sw_rise_out, sw_fall_out;
  logic           sw_changed_out;

  switch_debouncer #(
    .NUM_SW         (NSw),
    .SYNC_STAGES    (Sync),
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sw_raw_in     (sw_raw_in),
    .sw_out        (sw_out),
    .sw_rise_out   (sw_rise_out),
    .sw_fall_out   (sw_fall_out),
    .sw_changed_out(sw_changed_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: raw samples travel a Sync-deep delay line; a bit flips once
  // its delayed value has disagreed with the output on Deb+1 consecutive edges.
  logic [NSw-1:0] dly_q[$];
  int             run[NSw];
  logic [NSw-1:0] m_out, m_rise, m_fall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    dly_q.delete();
    for (int k = 0; k < Sync; k++) dly_q.push_back('0);
    for (int i = 0; i < NSw; i++) run[i] = 0;
    m_out  = '0;
    m_rise = '0;
    m_fall = '0;
  endtask

  task automatic model_edge(input logic r, input logic [NSw-1:0] raw);
    logic [NSw-1:0] s;
    if (r) begin
      model_reset();
      return;
    end
    s      = dly_q.pop_front();
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < NSw; i++) begin
      run[i] = (s[i] != m_out[i]) ? run[i] + 1 : 0;
      if (run[i] == Deb + 1) begin
        if (m_out[i]) m_fall[i] = 1'b1;
        else          m_rise[i] = 1'b1;
        m_out[i] = ~m_out[i];
        run[i]   = 0;
      end
    end
    dly_q.push_back(raw);
  endtask

  task automatic step(input logic r, input logic [NSw-1:0] raw);
    rst       = r;
    sw_raw_in = raw;
    @(posedge clk);
    model_edge(r, raw);
    cyc++;
    @(negedge clk);
    check("sw_out", 32'(sw_out), 32'(m_out));
    check("sw_rise_out", 32'(sw_rise_out), 32'(m_rise));
    check("sw_fall_out", 32'(sw_fall_out), 32'(m_fall));
    check("sw_changed_out", 32'(sw_changed_out), 32'(|(m_rise | m_fall)));
  endtask

  initial begin
    logic [NSw-1:0] rv;
    model_reset();
    @(negedge clk);

    // Reset with switches high, then re-qualify from scratch.
    for (int k = 0; k < 3; k++) step(1'b1, 2'b11);
    for (int k = 0; k < 10; k++) step(1'b0, 2'b11);
    check("after_reset_level", 32'(sw_out), 32'h3);
    for (int k = 0; k < 10; k++) step(1'b0, 2'b00);
    for (int k = 0; k < 2; k++) step(1'b1, 2'b00);
    for (int k = 0; k < 3; k++) step(1'b0, 2'b00);

    // Clean rise on bit 0: step k samples edge E+k.
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 2'b01);
      if (k == 5) check("rise_early", 32'(sw_out[0]), 32'h0);
      if (k == 6) begin
        check("rise_level", 32'(sw_out[0]), 32'h1);
        check("rise_pulse", 32'(sw_rise_out[0]), 32'h1);
        check("rise_changed", 32'(sw_changed_out), 32'h1);
      end
      if (k == 7) check("rise_pulse_end", 32'(sw_rise_out[0]), 32'h0);
    end

    // Glitch on bit 1 shorter than the debounce window.
    for (int k = 0; k < 3; k++) step(1'b0, 2'b11);
    for (int k = 0; k < 20; k++) step(1'b0, 2'b01);
    check("glitch_level", 32'(sw_out), 32'h1);

    // Bounce on bit 0 from a settled low.
    for (int k = 0; k < 12; k++) step(1'b0, 2'b00);
    for (int p = 0; p < 5; p++) begin
      rv = (p % 2 == 0) ? 2'b01 : 2'b00;
      step(1'b0, rv);
      step(1'b0, rv);
    end
    for (int k = 0; k < 12; k++) step(1'b0, 2'b01);
    check("bounce_level", 32'(sw_out), 32'h1);

    // Simultaneous rise on bit 1 and fall on bit 0.
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 2'b10);
      if (k == 6) begin
        check("simul_level", 32'(sw_out), 32'h2);
        check("simul_rise", 32'(sw_rise_out), 32'h2);
        check("simul_fall", 32'(sw_fall_out), 32'h1);
      end
    end

    // Reset in the middle of a pending rise on bit 0.
    for (int k = 0; k < 4; k++) step(1'b0, 2'b11);
    step(1'b1, 2'b11);
    for (int k = 0; k < 12; k++) step(1'b0, 2'b11);
    check("midwait_level", 32'(sw_out), 32'h3);

    // Random activity: bits flip rarely enough that some changes qualify.
    rv = 2'b00;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NSw; i++)
        if ($urandom_range(7) == 0) rv[i] = ~rv[i];
      step(($urandom_range(299) == 0), rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
